// File: rtl/cdc_sync_bits_filt.sv
// ---------------------------------------------------------------------------
// cdc_sync_bits_filt
//   Multi-bit level synchronizer with a glitch filter and edge detection on
//   each bit. Quasi-static asynchronous levels (buttons, status lines,
//   external IRQs) pass through SYNC_STAGES flops into the out_clk domain.
//   A new level is accepted only once it has been stable for FILTER_CYCLES
//   cycles. Every accepted edge gives a one-cycle rise or fall pulse.
//   The bits are independent of each other, so a multi-bit value is not
//   guaranteed to arrive coherently. Use a handshake CDC for that case.
//
// Parameters
//   NUM_OF_BITS    number of independent bits
//   SYNC_STAGES    synchronizer depth, 2..4
//   FILTER_CYCLES  stable cycles needed to accept a new level (0 or 1 = none)
//   RESET_VALUE    value loaded into the sync chain and cdc_out on reset
//
// Ports
//   out_clk     in   1            destination clock
//   out_reset   in   1            synchronous reset, active-high
//   cdc_in      in   NUM_OF_BITS  asynchronous input levels
//   cdc_out     out  NUM_OF_BITS  synchronized, filtered levels
//   cdc_rise    out  NUM_OF_BITS  1-cycle pulse when a cdc_out bit goes 0->1
//   cdc_fall    out  NUM_OF_BITS  1-cycle pulse when a cdc_out bit goes 1->0
//   cdc_change  out  1            OR of all rise/fall pulses
// ---------------------------------------------------------------------------
module cdc_sync_bits_filt #(
  parameter int unsigned               NUM_OF_BITS   = 1,
  parameter int unsigned               SYNC_STAGES   = 2,
  parameter int unsigned               FILTER_CYCLES = 4,
  parameter logic [NUM_OF_BITS-1:0]    RESET_VALUE   = '0
) (
  input  logic                   out_clk,
  input  logic                   out_reset,
  input  logic [NUM_OF_BITS-1:0] cdc_in,
  output logic [NUM_OF_BITS-1:0] cdc_out,
  output logic [NUM_OF_BITS-1:0] cdc_rise,
  output logic [NUM_OF_BITS-1:0] cdc_fall,
  output logic                   cdc_change
);

  // A filter length of 0 behaves like 1: the level is accepted on the first
  // cycle that the synchronized value differs from cdc_out.
  localparam int unsigned F_EFF = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
  localparam int unsigned CNT_W = ($clog2(F_EFF + 1) < 1) ? 1 : $clog2(F_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(F_EFF - 1);

  // Synchronizer chain. Nothing sits between the stages, so the tools can
  // place these flops together.
  (* ASYNC_REG = "true" *) logic [NUM_OF_BITS-1:0] r_sync [SYNC_STAGES];

  logic [NUM_OF_BITS-1:0] r_out;
  logic [NUM_OF_BITS-1:0] r_rise;
  logic [NUM_OF_BITS-1:0] r_fall;
  logic                   r_change;
  logic [CNT_W-1:0]       r_cnt [NUM_OF_BITS];

  logic [NUM_OF_BITS-1:0] w_s;
  logic [NUM_OF_BITS-1:0] w_diff;
  logic [NUM_OF_BITS-1:0] w_update;
  logic [NUM_OF_BITS-1:0] w_rise_nxt;
  logic [NUM_OF_BITS-1:0] w_fall_nxt;
  logic [NUM_OF_BITS-1:0] w_out_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt [NUM_OF_BITS];

  always_ff @(posedge out_clk) begin
    if (out_reset) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= RESET_VALUE;
      end
    end else begin
      r_sync[0] <= cdc_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // The counter holds how many edges in a row the synchronized level has
  // differed from cdc_out. If the level returns to cdc_out, the count goes
  // back to zero, so a glitch shorter than the filter length leaves nothing.
  always_comb begin
    w_diff   = w_s ^ r_out;
    w_update = '0;
    for (int i = 0; i < int'(NUM_OF_BITS); i++) begin
      w_cnt_nxt[i] = '0;
      if (w_diff[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_update[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
    w_rise_nxt = w_update & w_s;
    w_fall_nxt = w_update & ~w_s;
    w_out_nxt  = (r_out & ~w_update) | (w_s & w_update);
  end

  // The pulses are registered in the same edge as cdc_out. The cycle that
  // shows the new level is therefore the cycle that carries the pulse.
  always_ff @(posedge out_clk) begin
    if (out_reset) begin
      r_out    <= RESET_VALUE;
      r_rise   <= '0;
      r_fall   <= '0;
      r_change <= 1'b0;
      for (int i = 0; i < int'(NUM_OF_BITS); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_out    <= w_out_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_change <= |(w_rise_nxt | w_fall_nxt);
      for (int i = 0; i < int'(NUM_OF_BITS); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign cdc_out    = r_out;
  assign cdc_rise   = r_rise;
  assign cdc_fall   = r_fall;
  assign cdc_change = r_change;

endmodule

// File: tb/tb_cdc_sync_bits_filt.sv
// ---------------------------------------------------------------------------
// tb_cdc_sync_bits_filt
//   Six instances of the synchronizer share one clock, one reset and one
//   4-bit input, and each instance uses a different depth, filter length or
//   reset value. A behavioural model pushes the expected outputs for every
//   clock edge into a queue. A monitor pops them on the falling edge and
//   compares them with all six instances. Directed sequences add checks on
//   latency, glitch rejection and reset.
// ---------------------------------------------------------------------------
module tb_cdc_sync_bits_filt;

  localparam int          NI = 6;
  localparam int          P_S  [NI] = '{2, 2, 3, 3, 4, 4};
  localparam int          P_F  [NI] = '{4, 4, 0, 1, 15, 4};
  localparam logic [3:0]  P_RV [NI] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam int          EW = 13;

  logic       clk;
  logic       rst;
  logic [3:0] cdc_in;

  logic [3:0] o_out  [NI];
  logic [3:0] o_rise [NI];
  logic [3:0] o_fall [NI];
  logic       o_chg  [NI];

  int n_chk;
  int n_fail;
  int chg_cnt [NI];

  logic [NI*EW-1:0] q_exp [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    cdc_sync_bits_filt #(
      .NUM_OF_BITS  (4),
      .SYNC_STAGES  (P_S[k]),
      .FILTER_CYCLES(P_F[k]),
      .RESET_VALUE  (P_RV[k])
    ) u_dut (
      .out_clk   (clk),
      .out_reset (rst),
      .cdc_in    (cdc_in),
      .cdc_out   (o_out[k]),
      .cdc_rise  (o_rise[k]),
      .cdc_fall  (o_fall[k]),
      .cdc_change(o_chg[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  // Reference model. At each edge it advances every instance by one step.
  logic [3:0] m_sync [NI][4];
  logic [3:0] m_out  [NI];
  int         m_run  [NI][4];

  always @(posedge clk) begin
    logic [NI*EW-1:0] e;
    logic [3:0]       s, r, f;
    int               fe;
    e = '0;
    for (int k = 0; k < NI; k++) begin
      r = '0;
      f = '0;
      if (rst) begin
        for (int j = 0; j < 4; j++) m_sync[k][j] = P_RV[k];
        m_out[k] = P_RV[k];
        for (int b = 0; b < 4; b++) m_run[k][b] = 0;
      end else begin
        s  = m_sync[k][P_S[k]-1];
        fe = (P_F[k] < 1) ? 1 : P_F[k];
        for (int b = 0; b < 4; b++) begin
          if (s[b] == m_out[k][b]) begin
            m_run[k][b] = 0;
          end else begin
            m_run[k][b] = m_run[k][b] + 1;
            if (m_run[k][b] >= fe) begin
              m_run[k][b] = 0;
              m_out[k][b] = s[b];
              if (s[b]) r[b] = 1'b1;
              else      f[b] = 1'b1;
            end
          end
        end
        for (int j = 3; j > 0; j--) m_sync[k][j] = m_sync[k][j-1];
        m_sync[k][0] = cdc_in;
      end
      e[k*EW +: 4]     = m_out[k];
      e[k*EW + 4 +: 4] = r;
      e[k*EW + 8 +: 4] = f;
      e[k*EW + 12]     = |(r | f);
    end
    q_exp.push_back(e);
  end

  always @(negedge clk) begin
    logic [NI*EW-1:0] e;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("d%0d_out", k),  32'(o_out[k]),  32'(e[k*EW +: 4]));
        chk($sformatf("d%0d_rise", k), 32'(o_rise[k]), 32'(e[k*EW + 4 +: 4]));
        chk($sformatf("d%0d_fall", k), 32'(o_fall[k]), 32'(e[k*EW + 8 +: 4]));
        chk($sformatf("d%0d_chg", k),  32'(o_chg[k]),  32'(e[k*EW + 12]));
        chk($sformatf("d%0d_rf_excl", k), 32'(o_rise[k] & o_fall[k]), 32'h0);
        if (o_chg[k] === 1'b1) chg_cnt[k]++;
      end
    end
  end

  // Drive val (and optionally release reset) just after an edge. Then count
  // edges until each selected instance shows val. The expected count is
  // SYNC_STAGES + max(FILTER_CYCLES,1).
  task automatic measure(input logic [3:0] val, input logic [NI-1:0] mask, input bit rel);
    int lat [NI];
    for (int k = 0; k < NI; k++) lat[k] = -1;
    @(posedge clk);
    #1;
    cdc_in = val;
    if (rel) rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      for (int k = 0; k < NI; k++)
        if (mask[k] && lat[k] < 0 && o_out[k] === val) lat[k] = n;
    end
    for (int k = 0; k < NI; k++)
      if (mask[k])
        chk($sformatf("d%0d_lat", k), 32'(lat[k]), 32'(P_S[k] + ((P_F[k] < 1) ? 1 : P_F[k])));
  endtask

  task automatic clear_cnt();
    for (int k = 0; k < NI; k++) chg_cnt[k] = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    cdc_in = 4'h0;
    clear_cnt();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_d0", 32'(o_out[0]), 32'h0);
    chk("rst_out_d1", 32'(o_out[1]), 32'hF);
    chk("rst_chg_d1", 32'(o_chg[1]), 32'h0);

    // Release with a reset value of F and the input at 0. Only instance 1 moves.
    measure(4'h0, 6'b000010, 1'b1);
    chk("rel_chg_d1", 32'(chg_cnt[1]), 32'h1);
    chk("rel_chg_d0", 32'(chg_cnt[0]), 32'h0);

    // A clean step on bit 0.
    clear_cnt();
    measure(4'h1, 6'b111111, 1'b0);
    chk("step_chg_d0", 32'(chg_cnt[0]), 32'h1);
    chk("step_out_d0", 32'(o_out[0]), 32'h1);

    // A 3-cycle glitch on bit 1 is rejected when the filter length is 4 or more.
    clear_cnt();
    @(posedge clk); #1; cdc_in = 4'h3;
    repeat (3) @(posedge clk);
    #1; cdc_in = 4'h1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("glitch_chg_d0", 32'(chg_cnt[0]), 32'h0);
    chk("glitch_chg_d1", 32'(chg_cnt[1]), 32'h0);
    chk("glitch_chg_d4", 32'(chg_cnt[4]), 32'h0);
    chk("glitch_chg_d5", 32'(chg_cnt[5]), 32'h0);
    chk("glitch_chg_d2", 32'(chg_cnt[2]), 32'h2);
    chk("glitch_out_d0", 32'(o_out[0]), 32'h1);

    // All bits step down and then up. After that, toggle every edge: with no
    // filter, each toggle must give exactly one pulse.
    measure(4'h0, 6'b111111, 1'b0);
    measure(4'hF, 6'b111111, 1'b0);
    clear_cnt();
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1; cdc_in = ~cdc_in;
    end
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("tog_chg_d2", 32'(chg_cnt[2]), 32'd10);
    chk("tog_chg_d3", 32'(chg_cnt[3]), 32'd10);
    chk("tog_chg_d0", 32'(chg_cnt[0]), 32'd0);

    // Reset arrives 2 cycles into an accept count. The full latency starts again after release.
    measure(4'h0, 6'b111111, 1'b0);
    clear_cnt();
    @(posedge clk); #1; cdc_in = 4'h1;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    measure(4'h1, 6'b111111, 1'b1);
    chk("rstmid_chg_d0", 32'(chg_cnt[0]), 32'h1);
    chk("rstmid_chg_d1", 32'(chg_cnt[1]), 32'h1);

    // Random levels with random hold times and an occasional reset.
    for (int it = 0; it < 1500; it++) begin
      @(posedge clk);
      #1;
      rst    = ($urandom_range(0, 39) == 0);
      cdc_in = 4'($urandom);
      repeat ($urandom_range(0, 18)) @(posedge clk);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1;
    chk("q_drained", 32'(q_exp.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
